hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC core. It watches the ID, EX, MEM and WB stage fields and drives two groups of outputs:
- hold, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers;
- operand-forwarding selects for the EX stage.

It handles load-use stalls, taken-branch redirects and data-memory wait freezes. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// It drives the hold/bubble/flush controls, picks the EX operand
// forwarding sources, and keeps the stall/flush counters and a sticky
// memory-timeout flag.

// Forwarding source select for one EX operand. Forwarding from EX/MEM
// wins over MEM/WB. A load in EX/MEM has no result yet, so it is never
// forwarded from there.
module hazard_fwd_sel #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_rw,
  input  logic             i_mem_mr,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_rw,
  output logic [1:0]       o_sel
);
  // pick the youngest producer of i_src that has its value ready
  always_comb begin
    o_sel = 2'b00;
    if (i_mem_rw && !i_mem_mr && (i_mem_rd == i_src)) o_sel = 2'b01;
    else if (i_wb_rw && (i_wb_rd == i_src))           o_sel = 2'b10;
  end
endmodule

module hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_useRs,
  input  logic             ID_useRt,
  input  logic [REG_W-1:0] EX_Rs,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] MEM_Rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [REG_W-1:0] WB_Rd,
  input  logic             WB_RegWrite,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);
  localparam int BW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] TO_MAX = BW'(TIMEOUT);

  // Pipeline mode for this cycle, chosen in priority order.
  typedef enum logic [1:0] {RUN, LOAD_STALL, REDIRECT, FREEZE} mode_e;

  logic              w_load_use;
  mode_e             w_mode;
  logic [1:0][1:0]   w_fwd;
  logic [BW-1:0]     r_busy_cnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_flush;

  // A load in EX whose destination is read by the instruction in ID.
  // Every register is real, so R0 matches like any other register.
  assign w_load_use = EX_MemRead && EX_RegWrite &&
                      ((ID_useRs && (ID_Rs == EX_Rd)) ||
                       (ID_useRt && (ID_Rt == EX_Rd)));

  // Mode select. A freeze masks everything because EX re-presents its
  // branch/load on the first free cycle. A redirect discards a load-use
  // because the stalled instruction is on the wrong path.
  always_comb begin
    w_mode = RUN;
    if (mem_busy)          w_mode = FREEZE;
    else if (branch_taken) w_mode = REDIRECT;
    else if (w_load_use)   w_mode = LOAD_STALL;
  end

  // Drive the pipeline register controls from the mode. All are forced
  // low while reset is asserted.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (reset) begin
      case (w_mode)
        FREEZE: begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
        end
        REDIRECT: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        LOAD_STALL: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One forwarding selector per EX operand: index 0 is A/Rs, 1 is B/Rt.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
      .i_src    ((g == 0) ? EX_Rs : EX_Rt),
      .i_mem_rd (MEM_Rd),
      .i_mem_rw (MEM_RegWrite),
      .i_mem_mr (MEM_MemRead),
      .i_wb_rd  (WB_Rd),
      .i_wb_rw  (WB_RegWrite),
      .o_sel    (w_fwd[g])
    );
  end

  assign fwdA = reset ? w_fwd[0] : 2'b00;
  assign fwdB = reset ? w_fwd[1] : 2'b00;

  // Count consecutive busy cycles and latch the timeout on the edge
  // where the run length reaches TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (mem_busy) begin
      if (r_busy_cnt != TO_MAX) r_busy_cnt <= r_busy_cnt + 1'b1;
      if (r_busy_cnt == TO_MAX - 1'b1) r_timeout <= 1'b1;
    end else begin
      r_busy_cnt <= '0;
    end
  end

  // Saturating performance counters, updated on the edge that ends the
  // counted cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (((w_mode == FREEZE) || (w_mode == LOAD_STALL)) && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      if ((w_mode == REDIRECT) && (r_flush != '1))
        r_flush <= r_flush + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
  assign mem_timeout  = r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand
// sequences for multi-cycle corners, and random stimulus against a
// behavioural model.
module tb_hazard_ctrl;
  localparam int REG_W   = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [3:0] id_rs, id_rt;
    logic       id_urs, id_urt;
    logic [3:0] ex_rs, ex_rt, ex_rd;
    logic       ex_rw, ex_mr;
    logic [3:0] mem_rd;
    logic       mem_rw, mem_mr;
    logic [3:0] wb_rd;
    logic       wb_rw, br, busy;
  } in_t;

  typedef struct {
    in_t        v;
    logic [5:0] ctl;   // {pc, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem}
    logic [1:0] fa, fb;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
  logic ID_useRs, ID_useRt, EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic WB_RegWrite, branch_taken, mem_busy;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, mem_timeout;
  logic [1:0] fwdA, fwdB;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_chk = 0, n_err = 0;
  int m_stall = 0, m_flush = 0, m_run = 0;
  logic m_to = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_useRs(ID_useRs), .ID_useRt(ID_useRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .fwdA(fwdA), .fwdB(fwdB),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  wire [5:0] ctl_w = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode from the priority rules, 3=freeze 2=redirect 1=stall 0=run.
  function automatic int m_mode(input in_t v);
    bit lu;
    lu = v.ex_mr && v.ex_rw && ((v.id_urs && v.id_rs == v.ex_rd) || (v.id_urt && v.id_rt == v.ex_rd));
    if (v.busy) return 3;
    if (v.br)   return 2;
    if (lu)     return 1;
    return 0;
  endfunction

  function automatic logic [5:0] m_ctl(input in_t v);
    case (m_mode(v))
      3: return 6'b110101;
      2: return 6'b001010;
      1: return 6'b110010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] src, input in_t v);
    if (v.mem_rw && !v.mem_mr && v.mem_rd == src) return 2'b01;
    if (v.wb_rw && v.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic drive(input in_t v);
    ID_Rs = v.id_rs; ID_Rt = v.id_rt; ID_useRs = v.id_urs; ID_useRt = v.id_urt;
    EX_Rs = v.ex_rs; EX_Rt = v.ex_rt; EX_Rd = v.ex_rd;
    EX_RegWrite = v.ex_rw; EX_MemRead = v.ex_mr;
    MEM_Rd = v.mem_rd; MEM_RegWrite = v.mem_rw; MEM_MemRead = v.mem_mr;
    WB_Rd = v.wb_rd; WB_RegWrite = v.wb_rw;
    branch_taken = v.br; mem_busy = v.busy;
  endtask

  // One cycle: drive, check at negedge, then advance the model at posedge.
  task automatic apply(input in_t v, input logic [5:0] ectl, input logic [1:0] efa,
                       input logic [1:0] efb, input string nm);
    int md;
    drive(v);
    @(negedge clk);
    chk({nm, ".ctl"}, ctl_w, ectl);
    chk({nm, ".fwdA"}, fwdA, efa);
    chk({nm, ".fwdB"}, fwdB, efb);
    chk({nm, ".stall"}, stall_cycles, sat(m_stall));
    chk({nm, ".flush"}, flush_count, sat(m_flush));
    chk({nm, ".timeout"}, mem_timeout, m_to);
    @(posedge clk);
    md = m_mode(v);
    if (md == 3 || md == 1) m_stall++;
    if (md == 2) m_flush++;
    m_run = v.busy ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_to = 1'b1;
    #1;
  endtask

  task automatic apply_m(input in_t v, input string nm);
    apply(v, m_ctl(v), m_fwd(v.ex_rs, v), m_fwd(v.ex_rt, v), nm);
  endtask

  // Asynchronous reset mid-cycle with whatever inputs are present.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst.ctl", ctl_w, 6'b0);
    chk("rst.fwd", {fwdA, fwdB}, 4'b0);
    chk("rst.stall", stall_cycles, 0);
    chk("rst.flush", flush_count, 0);
    chk("rst.timeout", mem_timeout, 0);
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl[$];
  in_t  v, lu5;

  task automatic add(input in_t x, input logic [5:0] c, input logic [1:0] a, input logic [1:0] b);
    vec_t e;
    e.v = x; e.ctl = c; e.fa = a; e.fb = b;
    tbl.push_back(e);
  endtask

  initial begin
    // Reset with hazard-heavy inputs: outputs must still be 0.
    v = '0; v.busy = 1; v.br = 1; v.ex_rs = 3; v.mem_rd = 3; v.mem_rw = 1;
    drive(v);
    do_reset();

    // Directed vectors, expected values derived by hand.
    lu5 = '0; lu5.ex_mr = 1; lu5.ex_rw = 1; lu5.ex_rd = 5; lu5.id_rs = 5; lu5.id_urs = 1;
    v = '0;                                   add(v, 6'b000000, 2'b00, 2'b00);
    add(lu5, 6'b110010, 2'b00, 2'b00);
    v = lu5; v.id_rs = 2; v.id_rt = 5;        add(v, 6'b000000, 2'b00, 2'b00);
    v.id_urt = 1;                             add(v, 6'b110010, 2'b00, 2'b00);
    v = lu5; v.ex_rw = 0;                     add(v, 6'b000000, 2'b00, 2'b00);
    v = lu5; v.id_urs = 0;                    add(v, 6'b000000, 2'b00, 2'b00);
    v = lu5; v.br = 1;                        add(v, 6'b001010, 2'b00, 2'b00);
    v.busy = 1;                               add(v, 6'b110101, 2'b00, 2'b00);
    v = '0; v.ex_rs = 3; v.mem_rd = 3; v.mem_rw = 1; v.wb_rd = 3; v.wb_rw = 1;
    v.ex_rt = 1;                              add(v, 6'b000000, 2'b01, 2'b00);
    v.mem_mr = 1;                             add(v, 6'b000000, 2'b10, 2'b00);
    v.wb_rw = 0;                              add(v, 6'b000000, 2'b00, 2'b00);
    v = '0; v.ex_rs = 2; v.ex_rt = 7; v.wb_rd = 7; v.wb_rw = 1;
                                              add(v, 6'b000000, 2'b00, 2'b10);
    v = '0; v.mem_rw = 1; v.wb_rw = 1;        add(v, 6'b000000, 2'b01, 2'b01);
    v = '0; v.wb_rw = 1; v.wb_rd = 0;         add(v, 6'b000000, 2'b10, 2'b10);
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].v, tbl[i].ctl, tbl[i].fa, tbl[i].fb, $sformatf("vec%0d", i));

    // Load-use: one stall cycle, then the consumer forwards from MEM/WB.
    do_reset();
    apply(lu5, 6'b110010, 2'b00, 2'b00, "lu.stall");
    v = '0; v.id_rs = 5; v.id_urs = 1; v.mem_rd = 5; v.mem_rw = 1; v.mem_mr = 1;
    apply(v, 6'b000000, 2'b00, 2'b00, "lu.bubble");
    chk("lu.stall_cnt", stall_cycles, 1);
    v = '0; v.ex_rs = 5; v.wb_rd = 5; v.wb_rw = 1;
    apply(v, 6'b000000, 2'b10, 2'b00, "lu.fwd");

    // Branch and load-use together: only the redirect counts.
    do_reset();
    v = lu5; v.br = 1;
    apply(v, 6'b001010, 2'b00, 2'b00, "brlu");
    chk("brlu.flush_cnt", flush_count, 1);
    chk("brlu.stall_cnt", stall_cycles, 0);

    // Freeze over a pending branch, redirect on the first free cycle.
    do_reset();
    v = '0; v.br = 1; v.busy = 1;
    for (int i = 0; i < 3; i++) apply(v, 6'b110101, 2'b00, 2'b00, "frz");
    v.busy = 0;
    apply(v, 6'b001010, 2'b00, 2'b00, "frz.redir");
    chk("frz.stall_cnt", stall_cycles, 3);
    chk("frz.flush_cnt", flush_count, 1);

    // Timeout boundary: TIMEOUT-1 busy cycles do not set it, TIMEOUT do.
    do_reset();
    v = '0; v.busy = 1;
    for (int i = 0; i < TIMEOUT - 1; i++) apply_m(v, "to63");
    v.busy = 0; apply_m(v, "to63.idle");
    chk("to63.flag", mem_timeout, 0);
    v.busy = 1;
    for (int i = 0; i < TIMEOUT; i++) apply_m(v, "to64");
    v.busy = 0; apply_m(v, "to64.idle");
    chk("to64.flag", mem_timeout, 1);
    apply_m(v, "to64.idle2");
    chk("to64.sticky", mem_timeout, 1);

    // Reset in the middle of a freeze, then stall counter saturation.
    v = '0; v.busy = 1;
    for (int i = 0; i < 3; i++) apply_m(v, "rfrz");
    do_reset();
    apply_m('0, "post_rst");
    for (int i = 0; i < 20; i++) apply(lu5, 6'b110010, 2'b00, 2'b00, "sat");
    chk("sat.stall_cnt", stall_cycles, 15);

    // Random stimulus with occasional long busy bursts and resets.
    begin
      int burst = 0;
      for (int i = 0; i < 3000; i++) begin
        v = in_t'({$urandom, $urandom});
        v.id_rs = 4'($urandom_range(0, 3)); v.id_rt = 4'($urandom_range(0, 3));
        v.ex_rs = 4'($urandom_range(0, 3)); v.ex_rt = 4'($urandom_range(0, 3));
        v.ex_rd = 4'($urandom_range(0, 3)); v.mem_rd = 4'($urandom_range(0, 3));
        v.wb_rd = 4'($urandom_range(0, 3));
        v.br = ($urandom_range(0, 4) == 0);
        if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(60, 70);
        if (burst > 0) begin
          v.busy = 1; burst--;
        end else begin
          v.busy = ($urandom_range(0, 5) == 0);
        end
        apply_m(v, "rnd");
        if ($urandom_range(0, 399) == 0) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
